// File: rtl/hook_grab_controller.sv
// Hook grab controller: swing, launch, extend, retract and award sequencing.
// Ports: clk/resetN, enable, startOfFrame, fireKey, hook/object inputs; hook commands, speeds, grab/score outputs.
module hook_grab_controller #(
  parameter int BASE_EXT_SPEED = 8,
  parameter int ROT_SPEED      = 2,
  parameter int MAX_OUT_FRAMES = 255
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic       startOfFrame,
  input  logic       fireKey,
  input  logic       hookCollision,
  input  logic [3:0] objId,
  input  logic [2:0] objWeight,
  input  logic [7:0] objValue,
  input  logic       hookReturnedPulse,
  output logic       sendHook,
  output logic       forceReturn,
  output logic [8:0] extentionSpeed,
  output logic [8:0] rotationSpeed,
  output logic       grabbedValid,
  output logic [3:0] grabbedId,
  output logic       removeObj,
  output logic [7:0] scoreAdd,
  output logic       scoreAddValid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWING,
    S_LAUNCH,
    S_EXTEND,
    S_RET_EMPTY,
    S_RET_LOADED,
    S_AWARD
  } state_e;

  localparam logic [8:0] BASE9 = 9'(BASE_EXT_SPEED);
  localparam logic [8:0] ROT9  = 9'(ROT_SPEED);
  localparam logic [7:0] MAX8  = 8'(MAX_OUT_FRAMES);

  state_e     state_q, state_d;
  logic       fire_q;
  logic [7:0] frames_q, frames_d;
  logic [3:0] id_q, id_d;
  logic [2:0] wt_q, wt_d;
  logic [7:0] val_q, val_d;

  logic [7:0] frames_inc;
  logic [8:0] wt9;
  logic [8:0] loaded_speed;

  // saturating frame count
  assign frames_inc = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;

  // heavier load slows retraction, never below 1
  assign wt9 = {6'd0, wt_q};
  assign loaded_speed = (BASE9 > wt9) ? (BASE9 - wt9) : 9'd1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      fire_q   <= 1'b0;
      frames_q <= '0;
      id_q     <= '0;
      wt_q     <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      fire_q   <= fireKey;
      frames_q <= frames_d;
      id_q     <= id_d;
      wt_q     <= wt_d;
      val_q    <= val_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    id_d     = id_q;
    wt_d     = wt_q;
    val_d    = val_q;
    if (!enable) begin
      state_d  = S_IDLE;
      frames_d = '0;
      id_d     = '0;
      wt_d     = '0;
      val_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_SWING;
        S_SWING: begin
          if (fireKey && !fire_q) begin
            state_d  = S_LAUNCH;
            frames_d = '0;
          end
        end
        S_LAUNCH: begin
          if (startOfFrame) state_d = S_EXTEND;
        end
        S_EXTEND: begin
          if (startOfFrame) frames_d = frames_inc;
          // collision wins over a simultaneous return
          if (hookCollision) begin
            id_d    = objId;
            wt_d    = objWeight;
            val_d   = objValue;
            state_d = S_RET_LOADED;
          end else if (hookReturnedPulse) begin
            state_d = S_SWING;
          end else if (startOfFrame && frames_inc >= MAX8) begin
            state_d = S_RET_EMPTY;
          end
        end
        S_RET_EMPTY: begin
          if (hookReturnedPulse) state_d = S_SWING;
        end
        S_RET_LOADED: begin
          if (hookReturnedPulse) state_d = S_AWARD;
        end
        S_AWARD: state_d = S_SWING;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sendHook       = (state_q == S_LAUNCH);
  assign forceReturn    = (state_q == S_RET_EMPTY) ||
                          (state_q == S_RET_LOADED);
  assign rotationSpeed  = (state_q == S_SWING) ? ROT9 : 9'd0;
  assign extentionSpeed = (state_q == S_RET_LOADED) ? loaded_speed
                                                    : BASE9;
  assign grabbedValid   = (state_q == S_RET_LOADED) ||
                          (state_q == S_AWARD);
  assign grabbedId      = grabbedValid ? id_q : 4'd0;
  assign removeObj      = (state_q == S_AWARD);
  assign scoreAddValid  = (state_q == S_AWARD);
  assign scoreAdd       = (state_q == S_AWARD) ? val_q : 8'd0;

endmodule

// File: tb/tb_hook_grab_controller.sv
// Testbench for hook_grab_controller: vector table, directed corner
// sequences and randomized stimulus against a reference model.
module tb_hook_grab_controller;

  logic clk;
  logic resetN;
  logic enable;
  logic startOfFrame;
  logic fireKey;
  logic hookCollision;
  logic [3:0] objId;
  logic [2:0] objWeight;
  logic [7:0] objValue;
  logic hookReturnedPulse;

  logic sendHook, forceReturn, grabbedValid;
  logic removeObj, scoreAddValid;
  logic [8:0] extentionSpeed, rotationSpeed;
  logic [3:0] grabbedId;
  logic [7:0] scoreAdd;

  logic b_send, b_frc, b_gv, b_rm, b_sav;
  logic [8:0] b_ext, b_rot;
  logic [3:0] b_gid;
  logic [7:0] b_sadd;

  int checks = 0;
  int errors = 0;

  hook_grab_controller u_dut (
    .clk(clk), .resetN(resetN), .enable(enable),
    .startOfFrame(startOfFrame), .fireKey(fireKey),
    .hookCollision(hookCollision), .objId(objId),
    .objWeight(objWeight), .objValue(objValue),
    .hookReturnedPulse(hookReturnedPulse),
    .sendHook(sendHook), .forceReturn(forceReturn),
    .extentionSpeed(extentionSpeed),
    .rotationSpeed(rotationSpeed),
    .grabbedValid(grabbedValid), .grabbedId(grabbedId),
    .removeObj(removeObj), .scoreAdd(scoreAdd),
    .scoreAddValid(scoreAddValid)
  );

  hook_grab_controller #(.BASE_EXT_SPEED(4)) u_b4 (
    .clk(clk), .resetN(resetN), .enable(enable),
    .startOfFrame(startOfFrame), .fireKey(fireKey),
    .hookCollision(hookCollision), .objId(objId),
    .objWeight(objWeight), .objValue(objValue),
    .hookReturnedPulse(hookReturnedPulse),
    .sendHook(b_send), .forceReturn(b_frc),
    .extentionSpeed(b_ext), .rotationSpeed(b_rot),
    .grabbedValid(b_gv), .grabbedId(b_gid),
    .removeObj(b_rm), .scoreAdd(b_sadd),
    .scoreAddValid(b_sav)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: game phase plus the object on the hook
  localparam int P_IDLE = 0, P_SWING = 1, P_LAUNCH = 2;
  localparam int P_EXTEND = 3, P_RE = 4, P_RL = 5, P_AWARD = 6;
  localparam int MAXF = 255;

  int ph, m_id, m_wt, m_val, m_frames;
  bit m_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    ph = P_IDLE;
    m_id = 0; m_wt = 0; m_val = 0; m_frames = 0;
    m_prev = 0;
  endtask

  function automatic int m_ext(input int base);
    if (ph != P_RL) return base;
    return (base - m_wt < 1) ? 1 : base - m_wt;
  endfunction

  task automatic m_step();
    if (!enable) begin
      ph = P_IDLE;
      m_id = 0; m_wt = 0; m_val = 0; m_frames = 0;
    end else begin
      case (ph)
        P_IDLE: ph = P_SWING;
        P_SWING:
          if (fireKey && !m_prev) begin
            ph = P_LAUNCH;
            m_frames = 0;
          end
        P_LAUNCH: if (startOfFrame) ph = P_EXTEND;
        P_EXTEND:
          if (hookCollision) begin
            m_id = int'(objId);
            m_wt = int'(objWeight);
            m_val = int'(objValue);
            ph = P_RL;
          end else if (hookReturnedPulse) begin
            ph = P_SWING;
          end else if (startOfFrame) begin
            m_frames = (m_frames < 255) ? m_frames + 1 : 255;
            if (m_frames >= MAXF) ph = P_RE;
          end
        P_RE: if (hookReturnedPulse) ph = P_SWING;
        P_RL: if (hookReturnedPulse) ph = P_AWARD;
        P_AWARD: ph = P_SWING;
        default: ph = P_IDLE;
      endcase
    end
    m_prev = fireKey;
  endtask

  task automatic m_check();
    bit gv;
    gv = (ph == P_RL) || (ph == P_AWARD);
    chk("m_send", 32'(sendHook), 32'(ph == P_LAUNCH));
    chk("m_force", 32'(forceReturn),
        32'((ph == P_RE) || (ph == P_RL)));
    chk("m_rot", 32'(rotationSpeed), (ph == P_SWING) ? 2 : 0);
    chk("m_ext8", 32'(extentionSpeed), m_ext(8));
    chk("m_ext4", 32'(b_ext), m_ext(4));
    chk("m_gv", 32'(grabbedValid), 32'(gv));
    chk("m_gid", 32'(grabbedId), gv ? m_id : 0);
    chk("m_rm", 32'(removeObj), 32'(ph == P_AWARD));
    chk("m_sav", 32'(scoreAddValid), 32'(ph == P_AWARD));
    chk("m_sadd", 32'(scoreAdd), (ph == P_AWARD) ? m_val : 0);
  endtask

  // inputs are set at the falling edge before each call
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    m_check();
    @(negedge clk);
  endtask

  task automatic clr_in();
    startOfFrame = 0; fireKey = 0; hookCollision = 0;
    hookReturnedPulse = 0; objId = 0; objWeight = 0; objValue = 0;
  endtask

  task automatic do_reset();
    resetN = 0;
    #1;
    m_reset();
    chk("rst_send", 32'(sendHook), 0);
    chk("rst_force", 32'(forceReturn), 0);
    chk("rst_ext", 32'(extentionSpeed), 8);
    chk("rst_ext4", 32'(b_ext), 4);
    chk("rst_rot", 32'(rotationSpeed), 0);
    chk("rst_gv", 32'(grabbedValid), 0);
    chk("rst_gid", 32'(grabbedId), 0);
    chk("rst_rm", 32'(removeObj), 0);
    chk("rst_sadd", 32'(scoreAdd), 0);
    chk("rst_sav", 32'(scoreAddValid), 0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1;
  endtask

  // from reset: SWING, then launch into EXTEND
  task automatic to_extend();
    enable = 1; clr_in();
    tick();
    fireKey = 1; tick();
    startOfFrame = 1; tick();
    clr_in();
  endtask

  task automatic grab(input logic [3:0] id, input logic [2:0] wt,
                      input logic [7:0] val);
    hookCollision = 1; objId = id; objWeight = wt; objValue = val;
    tick();
    clr_in();
  endtask

  typedef struct {
    logic en, fire, sof, col, ret;
    logic [3:0] id;
    logic [2:0] wt;
    logic [7:0] val;
    logic send, frc;
    logic [8:0] ext, rot;
    logic gv;
    logic [3:0] gid;
    logic rm;
    logic [7:0] sadd;
    logic sav;
  } vec_t;

  function automatic vec_t mk(
    input logic en, fire, sof, col, ret,
    input logic [3:0] id, input logic [2:0] wt, input logic [7:0] val,
    input logic send, frc, input logic [8:0] ext, rot,
    input logic gv, input logic [3:0] gid, input logic rm,
    input logic [7:0] sadd, input logic sav);
    vec_t v;
    v.en = en; v.fire = fire; v.sof = sof; v.col = col; v.ret = ret;
    v.id = id; v.wt = wt; v.val = val;
    v.send = send; v.frc = frc; v.ext = ext; v.rot = rot;
    v.gv = gv; v.gid = gid; v.rm = rm; v.sadd = sadd; v.sav = sav;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    int cnt;
    // en fi sf co re id wt val | snd frc ext rot gv gid rm sadd sav
    tbl[0]  = mk(1,0,0,0,0, 0,0,0,   0,0,8,2, 0,0,0,0,0);
    tbl[1]  = mk(1,1,0,0,0, 0,0,0,   1,0,8,0, 0,0,0,0,0);
    tbl[2]  = mk(1,1,0,0,0, 0,0,0,   1,0,8,0, 0,0,0,0,0);
    tbl[3]  = mk(1,1,1,0,0, 0,0,0,   0,0,8,0, 0,0,0,0,0);
    tbl[4]  = mk(1,1,0,1,0, 5,3,50,  0,1,5,0, 1,5,0,0,0);
    tbl[5]  = mk(1,0,0,1,0, 9,1,99,  0,1,5,0, 1,5,0,0,0);
    tbl[6]  = mk(1,0,0,0,1, 0,0,0,   0,0,8,0, 1,5,1,50,1);
    tbl[7]  = mk(1,0,0,0,0, 0,0,0,   0,0,8,2, 0,0,0,0,0);
    tbl[8]  = mk(1,1,0,0,0, 0,0,0,   1,0,8,0, 0,0,0,0,0);
    tbl[9]  = mk(1,1,1,0,0, 0,0,0,   0,0,8,0, 0,0,0,0,0);
    tbl[10] = mk(1,1,0,0,1, 0,0,0,   0,0,8,2, 0,0,0,0,0);
    tbl[11] = mk(1,1,0,0,0, 0,0,0,   0,0,8,2, 0,0,0,0,0);
    tbl[12] = mk(0,0,0,0,0, 0,0,0,   0,0,8,0, 0,0,0,0,0);

    enable = 0; clr_in(); resetN = 1;
    m_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; fireKey = tbl[i].fire;
      startOfFrame = tbl[i].sof; hookCollision = tbl[i].col;
      hookReturnedPulse = tbl[i].ret; objId = tbl[i].id;
      objWeight = tbl[i].wt; objValue = tbl[i].val;
      tick();
      chk($sformatf("t%0d_send", i), 32'(sendHook), 32'(tbl[i].send));
      chk($sformatf("t%0d_frc", i), 32'(forceReturn), 32'(tbl[i].frc));
      chk($sformatf("t%0d_ext", i), 32'(extentionSpeed), 32'(tbl[i].ext));
      chk($sformatf("t%0d_rot", i), 32'(rotationSpeed), 32'(tbl[i].rot));
      chk($sformatf("t%0d_gv", i), 32'(grabbedValid), 32'(tbl[i].gv));
      chk($sformatf("t%0d_gid", i), 32'(grabbedId), 32'(tbl[i].gid));
      chk($sformatf("t%0d_rm", i), 32'(removeObj), 32'(tbl[i].rm));
      chk($sformatf("t%0d_sadd", i), 32'(scoreAdd), 32'(tbl[i].sadd));
      chk($sformatf("t%0d_sav", i), 32'(scoreAddValid), 32'(tbl[i].sav));
    end

    // launch held for 10 cycles, then a held fire must not relaunch
    do_reset();
    enable = 1; clr_in(); tick();
    fireKey = 1; tick();
    cnt = int'(sendHook);
    for (int i = 1; i <= 10; i++) begin
      startOfFrame = (i == 10);
      tick();
      cnt += int'(sendHook);
    end
    chk("launch_cycles", cnt, 10);
    chk("launch_ext_state", 32'(sendHook), 0);
    startOfFrame = 0; hookReturnedPulse = 1; tick();
    hookReturnedPulse = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(sendHook);
    end
    chk("held_no_relaunch", cnt, 0);
    chk("held_swing_rot", 32'(rotationSpeed), 2);

    // heavy object on both speed settings
    do_reset();
    to_extend();
    grab(4'd2, 3'd7, 8'd77);
    chk("heavy_ext8", 32'(extentionSpeed), 1);
    chk("heavy_ext4", 32'(b_ext), 1);
    hookReturnedPulse = 1; tick(); hookReturnedPulse = 0;
    chk("heavy_sadd", 32'(scoreAdd), 77);
    chk("heavy_sav", 32'(scoreAddValid), 1);

    // collision and return together: collision wins
    do_reset();
    to_extend();
    hookReturnedPulse = 1;
    grab(4'd11, 3'd2, 8'd9);
    chk("simul_force", 32'(forceReturn), 1);
    chk("simul_gv", 32'(grabbedValid), 1);
    chk("simul_gid", 32'(grabbedId), 11);
    chk("simul_ext4", 32'(b_ext), 2);

    // enable drop while loaded
    do_reset();
    to_extend();
    grab(4'd6, 3'd1, 8'd40);
    enable = 0; tick();
    chk("abort_en_gv", 32'(grabbedValid), 0);
    chk("abort_en_frc", 32'(forceReturn), 0);
    cnt = 0;
    enable = 1; hookReturnedPulse = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(scoreAddValid) + int'(removeObj);
    end
    hookReturnedPulse = 0;
    chk("abort_en_noaward", cnt, 0);

    // reset while loaded
    do_reset();
    to_extend();
    grab(4'd3, 3'd4, 8'd60);
    chk("pre_rst_gv", 32'(grabbedValid), 1);
    do_reset();
    cnt = 0;
    hookReturnedPulse = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt += int'(scoreAddValid) + int'(removeObj);
    end
    hookReturnedPulse = 0;
    chk("abort_rst_noaward", cnt, 0);

    // out for 255 frames forces a return, no score after it
    do_reset();
    to_extend();
    for (int k = 1; k <= 255; k++) begin
      startOfFrame = 1; tick();
      chk($sformatf("tmo_force_%0d", k), 32'(forceReturn),
          32'(k == 255));
      startOfFrame = 0; tick();
    end
    cnt = 0;
    hookReturnedPulse = 1; tick(); hookReturnedPulse = 0;
    chk("tmo_swing_rot", 32'(rotationSpeed), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(scoreAddValid);
    end
    chk("tmo_noscore", cnt, 0);

    // randomized traffic against the model
    do_reset();
    enable = 1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) fireKey = ~fireKey;
      startOfFrame = ($urandom_range(0, 4) == 0);
      hookCollision = ($urandom_range(0, 7) == 0);
      hookReturnedPulse = ($urandom_range(0, 9) == 0);
      objId = 4'($urandom);
      objWeight = 3'($urandom);
      objValue = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
